// File: rtl/pc_pkg.sv
//------------------------------------------------------------------------------
// Module   : pc_pkg
// Summary  : Shared defaults and command-select encoding for pc_sequencer.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package pc_pkg;

    localparam int PC_WIDTH_DEF     = 8;
    localparam int PC_DEPTH_DEF     = 4;
    localparam int PC_RESET_VEC_DEF = 0;

    typedef enum logic [2:0] {
        CMD_NONE = 3'd0,
        CMD_INC  = 3'd1,
        CMD_LD   = 3'd2,
        CMD_REL  = 3'd3,
        CMD_CALL = 3'd4,
        CMD_RET  = 3'd5
    } cmd_e;

endpackage

`default_nettype wire

// File: rtl/pc_return_stack.sv
//------------------------------------------------------------------------------
// Module   : pc_return_stack
// Summary  : DEPTH x WIDTH LIFO for return addresses; push-when-full and
//            pop-when-empty are silently ignored.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module pc_return_stack #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int SPW   = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] top,
    output logic [SPW-1:0]   sp,
    output logic             full,
    output logic             empty
);

    localparam int IDXW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [SPW-1:0]   sp_q;
    logic [SPW-1:0]   sp_m1;

    assign sp_m1 = sp_q - SPW'(1);
    assign full  = (sp_q == SPW'(DEPTH));
    assign empty = (sp_q == '0);
    assign sp    = sp_q;
    assign top   = empty ? '0 : mem_q[sp_m1[IDXW-1:0]];

    always_ff @(posedge clk) begin
        if (reset) begin
            sp_q <= '0;
        end else if (push && !full) begin
            sp_q <= sp_q + SPW'(1);
        end else if (pop && !empty) begin
            sp_q <= sp_m1;
        end
    end

    // Storage is deliberately not reset; only sp defines validity.
    always_ff @(posedge clk) begin
        if (!reset && push && !full) begin
            mem_q[sp_q[IDXW-1:0]] <= din;
        end
    end

endmodule

`default_nettype wire

// File: rtl/pc_sequencer.sv
//------------------------------------------------------------------------------
// Module   : pc_sequencer
// Summary  : Fetch-stage program counter with increment, load, call/return
//            stack and (when PC_REL_BRANCH_EN is defined) relative branch.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module pc_sequencer
    import pc_pkg::*;
#(
    parameter int               WIDTH     = PC_WIDTH_DEF,
    parameter int               DEPTH     = PC_DEPTH_DEF,
    parameter logic [WIDTH-1:0] RESET_VEC = WIDTH'(PC_RESET_VEC_DEF)
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         pc_enable,
    input  logic                         ld,
    input  logic [WIDTH-1:0]             inp,
    input  logic                         rel_br,
    input  logic [WIDTH-1:0]             offset,
    input  logic                         call,
    input  logic                         ret,
    output logic [WIDTH-1:0]             out,
    output logic [$clog2(DEPTH+1)-1:0]   sp,
    output logic                         stack_full,
    output logic                         stack_empty,
    output logic                         overflow,
    output logic                         underflow
);

    localparam int SPW = $clog2(DEPTH + 1);

    cmd_e             cmd;
    logic [WIDTH-1:0] pc_q, pc_d, pc_inc;
    logic             ovf_q, ovf_d, unf_q, unf_d;
    logic             push, pop;
    logic [WIDTH-1:0] stk_top;

`ifndef PC_REL_BRANCH_EN
    logic unused_rel;
    assign unused_rel = ^{rel_br, offset};
`endif

    assign pc_inc = pc_q + WIDTH'(1);

    always_comb begin
        cmd = CMD_NONE;
        if (ret)            cmd = CMD_RET;
        else if (call)      cmd = CMD_CALL;
        else if (ld)        cmd = CMD_LD;
`ifdef PC_REL_BRANCH_EN
        else if (rel_br)    cmd = CMD_REL;
`endif
        else if (pc_enable) cmd = CMD_INC;
    end

    always_comb begin
        pc_d  = pc_q;
        ovf_d = ovf_q;
        unf_d = unf_q;
        push  = 1'b0;
        pop   = 1'b0;
        case (cmd)
            CMD_INC: pc_d = pc_inc;
            CMD_LD:  pc_d = inp;
`ifdef PC_REL_BRANCH_EN
            CMD_REL: pc_d = pc_q + offset;
`endif
            CMD_CALL: begin
                if (stack_full) begin
                    ovf_d = 1'b1;
                end else begin
                    push = 1'b1;
                    pc_d = inp;
                end
            end
            CMD_RET: begin
                if (stack_empty) begin
                    unf_d = 1'b1;
                end else begin
                    pop  = 1'b1;
                    pc_d = stk_top;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q  <= RESET_VEC;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            pc_q  <= pc_d;
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end

    pc_return_stack #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .SPW   (SPW)
    ) u_stack (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .din   (pc_inc),
        .top   (stk_top),
        .sp    (sp),
        .full  (stack_full),
        .empty (stack_empty)
    );

    assign out       = pc_q;
    assign overflow  = ovf_q;
    assign underflow = unf_q;

endmodule

`default_nettype wire

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Parametrised successor to the 8-bit program counter: increment, absolute load and reset, plus signed relative branch and a hardware call/return stack.
- Sits in the fetch stage; drives the instruction-memory address from `out`.
- Control decode asserts one-cycle command strobes; the block resolves them by fixed priority.

Parameters:
- WIDTH, 8: PC and address width in bits.
- DEPTH, 4: return-stack entries (≥1).
- RESET_VEC, 0: PC value loaded on reset (WIDTH bits).

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- pc_enable  in  1  increment PC by 1.
- ld  in  1  load PC from `inp` (absolute jump).
- inp  in  WIDTH  absolute target for `ld` and `call`.
- rel_br  in  1  relative branch: PC ← PC + `offset`.
- offset  in  WIDTH  two's-complement branch offset.
- call  in  1  push PC+1, then PC ← `inp`.
- ret  in  1  pop the top of stack into PC.
- out  out  WIDTH  current PC.
- sp  out  clog2(DEPTH+1)  number of valid stack entries.
- stack_full  out  1  `sp` == DEPTH (combinational from `sp`).
- stack_empty  out  1  `sp` == 0 (combinational from `sp`).
- overflow  out  1  sticky: a call was attempted while the stack was full.
- underflow  out  1  sticky: a ret was attempted while the stack was empty.

Behaviour:
- Clock and reset: one clock `clk`; reset is synchronous and active-high.
- Reset values (on the first rising edge with `reset`=1):
  - `out` = RESET_VEC
  - `sp` = 0
  - `overflow` = 0, `underflow` = 0
  - stack contents don't-care, not cleared.
- Reset overrides every command in the same cycle.
- Priority when several strobes are high: reset > ret > call > ld > rel_br > pc_enable. Exactly one action per cycle; lower-priority strobes are ignored.
- Latency: each command takes effect at the next rising edge, so `out` is registered with 1-cycle latency. No internal FSM; the state is {PC, stack, sp, flags}.
- Increment: PC ← PC+1 mod 2^WIDTH, so 0xFF wraps to 0x00 at WIDTH=8.
- Relative branch: PC ← PC + offset mod 2^WIDTH, with `offset` signed. 0x02 + 0xFE = 0x00; 0xFE + 0x05 = 0x03.
- Call, stack not full:
  - stack[sp] ← PC+1 (mod 2^WIDTH)
  - sp ← sp+1
  - PC ← `inp`
- Call, stack full: no push, PC holds, `overflow` ← 1.
- Ret, stack not empty:
  - PC ← stack[sp-1]
  - sp ← sp-1
- Ret, stack empty: PC holds, `underflow` ← 1.
- `overflow` and `underflow` stay set until reset.
- No command asserted: PC holds.
- Back-to-back call/ret on consecutive cycles is supported at full rate with no bubbles.

Optional Feature:
- Macro: PC_REL_BRANCH_EN.
- Defined: `rel_br` and `offset` behave as specified above.
- Undefined: the `rel_br` and `offset` ports remain on the interface but are ignored. There is no adder beyond the incrementer, and priority collapses to reset > ret > call > ld > pc_enable.

Decomposition:
- Shared package `pc_pkg`:
  - default WIDTH/DEPTH localparams
  - RESET_VEC default
  - an enumerated command-select type (CMD_NONE, CMD_INC, CMD_LD, CMD_REL, CMD_CALL, CMD_RET) used by the priority encoder.
- One natural sub-module: `pc_return_stack`, a LIFO holding DEPTH×WIDTH storage with `push`, `pop`, `din`, `top`, `sp`, `full` and `empty`. Push-when-full and pop-when-empty are no-ops inside it; the sticky error flags live in the parent.

Test Plan (WIDTH=8, DEPTH=4, RESET_VEC=0):
- Reset, then `pc_enable`=1 for 5 cycles → `out` = 00,01,02,03,04,05; `sp`=0; both flags 0.
- `ld`=1 with `inp`=0x18 and `pc_enable`=1 together → `out`=0x18 (ld wins); then 3 increments → 0x1B. Next, load `inp`=0xFE, then increment twice → 0xFF, 0x00 (wrap).
- With PC=0x10: `call` `inp`=0x40 → `out`=0x40, `sp`=1; `call` `inp`=0x80 → `out`=0x80, `sp`=2; `ret` → 0x41, `sp`=1; `ret` → 0x11, `sp`=0, `stack_empty`=1.
- Four calls fill the stack (`stack_full`=1). A fifth call with `inp`=0x99 → PC unchanged, `sp`=4, `overflow`=1. Drain with 4 rets, then a fifth ret → PC holds, `underflow`=1. Both flags remain 1 until reset, and reset clears them.
- With PC_REL_BRANCH_EN defined: PC=0x20, `rel_br` with `offset`=0xF0 → 0x10; with `offset`=0x05 → 0x15. Undefined: the same stimulus leaves PC at 0x20.
- Reset asserted together with `call` while `sp`=2 → `out`=0, `sp`=0, no push, flags 0.
